// File: rtl/axi4_lite_pkg.sv
// Shared AXI4-Lite constants, FSM state types and address decode for the slave register bank.
// AXI4_LITE_SLAVE_REGS_SLVERR_EN: out-of-range accesses answer SLVERR instead of OKAY.
package axi4_lite_pkg;

    localparam int AXI_DATA_W = 32;
    localparam int AXI_STRB_W = 4;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

`ifdef AXI4_LITE_SLAVE_REGS_SLVERR_EN
    localparam logic [1:0] RESP_OOR = RESP_SLVERR;
`else
    localparam logic [1:0] RESP_OOR = RESP_OKAY;
`endif

    typedef enum logic [1:0] {W_IDLE, W_HAVE_A, W_HAVE_D, W_RESP} wr_state_e;
    typedef enum logic       {R_IDLE, R_DATA} rd_state_e;

    // word_addr is the byte address with bits [1:0] already dropped
    function automatic logic word_in_range(input logic [29:0] word_addr, input int unsigned num_regs);
        return 32'(word_addr) < num_regs;
    endfunction

endpackage

// File: rtl/axi4_lite_slave_write_fsm.sv
// AW/W capture and B channel: the write fires on the edge both halves are held, BVALID the cycle after.
// Readies are registered and drop while a half is buffered or the response waits on BREADY.
module axi4_lite_slave_write_fsm
    import axi4_lite_pkg::*;
#(
    parameter  int NUM_REGS = 16,
    localparam int IDX_W    = $clog2(NUM_REGS)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [29:0]           awaddr_i,
    input  logic                  awvalid_i,
    output logic                  awready_o,
    input  logic [AXI_DATA_W-1:0] wdata_i,
    input  logic [AXI_STRB_W-1:0] wstrb_i,
    input  logic                  wvalid_i,
    output logic                  wready_o,
    output logic                  bvalid_o,
    input  logic                  bready_i,
    output logic [1:0]            bresp_o,
    output logic                  wr_en_o,
    output logic [IDX_W-1:0]      wr_idx_o,
    output logic [AXI_DATA_W-1:0] wr_data_o,
    output logic [AXI_STRB_W-1:0] wr_strb_o
);

    wr_state_e             state_q, state_d;
    logic [29:0]           addr_q, addr_d;
    logic [AXI_DATA_W-1:0] data_q, data_d;
    logic [AXI_STRB_W-1:0] strb_q, strb_d;
    logic [1:0]            bresp_q, bresp_d;
    logic                  awready_q, awready_d;
    logic                  wready_q, wready_d;

    logic                  aw_hs, w_hs, fire, in_range;
    logic [29:0]           wr_addr;
    logic [AXI_DATA_W-1:0] wr_data;
    logic [AXI_STRB_W-1:0] wr_strb;

    assign aw_hs = awvalid_i & awready_q;
    assign w_hs  = wvalid_i & wready_q;

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        data_d   = data_q;
        strb_d   = strb_q;
        bresp_d  = bresp_q;
        fire     = 1'b0;
        wr_addr  = addr_q;
        wr_data  = data_q;
        wr_strb  = strb_q;
        case (state_q)
            W_IDLE: begin
                if (aw_hs && w_hs) begin
                    fire    = 1'b1;
                    wr_addr = awaddr_i;
                    wr_data = wdata_i;
                    wr_strb = wstrb_i;
                    state_d = W_RESP;
                end else if (aw_hs) begin
                    addr_d  = awaddr_i;
                    state_d = W_HAVE_A;
                end else if (w_hs) begin
                    data_d  = wdata_i;
                    strb_d  = wstrb_i;
                    state_d = W_HAVE_D;
                end
            end
            W_HAVE_A: begin
                if (w_hs) begin
                    fire    = 1'b1;
                    wr_data = wdata_i;
                    wr_strb = wstrb_i;
                    state_d = W_RESP;
                end
            end
            W_HAVE_D: begin
                if (aw_hs) begin
                    fire    = 1'b1;
                    wr_addr = awaddr_i;
                    state_d = W_RESP;
                end
            end
            W_RESP: begin
                if (bready_i) state_d = W_IDLE;
            end
        endcase
        in_range = word_in_range(wr_addr, NUM_REGS);
        if (fire) bresp_d = in_range ? RESP_OKAY : RESP_OOR;
        // Readies follow the state being entered so they are valid the cycle it is occupied
        awready_d = (state_d == W_IDLE) || (state_d == W_HAVE_D);
        wready_d  = (state_d == W_IDLE) || (state_d == W_HAVE_A);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= W_IDLE;
            addr_q    <= '0;
            data_q    <= '0;
            strb_q    <= '0;
            bresp_q   <= RESP_OKAY;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            strb_q    <= strb_d;
            bresp_q   <= bresp_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
        end
    end

    assign awready_o = awready_q;
    assign wready_o  = wready_q;
    assign bvalid_o  = (state_q == W_RESP);
    assign bresp_o   = bresp_q;
    assign wr_en_o   = fire & in_range & (|wr_strb);
    assign wr_idx_o  = wr_addr[IDX_W-1:0];
    assign wr_data_o = wr_data;
    assign wr_strb_o = wr_strb;

endmodule

// File: rtl/axi4_lite_slave_regs.sv
// AXI4-Lite register bank: byte-merged writes, RVALID one cycle after AR; read and write FSMs independent.
// R/B outputs hold while RREADY/BREADY low. AXI4_LITE_SLAVE_REGS_SLVERR_EN selects SLVERR for out-of-range.
module axi4_lite_slave_regs
    import axi4_lite_pkg::*;
#(
    parameter  int NUM_REGS = 16,
    localparam int IDX_W    = $clog2(NUM_REGS)
) (
    input  logic                     ACLK,
    input  logic                     ARESETn,
    input  logic [31:0]              AWADDR,
    input  logic [3:0]               AWCACHE,
    input  logic [2:0]               AWPROT,
    input  logic                     AWVALID,
    output logic                     AWREADY,
    input  logic [31:0]              WDATA,
    input  logic [3:0]               WSTRB,
    input  logic                     WVALID,
    output logic                     WREADY,
    output logic                     BVALID,
    input  logic                     BREADY,
    output logic [1:0]               BRESP,
    input  logic [31:0]              ARADDR,
    input  logic [3:0]               ARCACHE,
    input  logic [2:0]               ARPROT,
    input  logic                     ARVALID,
    output logic                     ARREADY,
    output logic [31:0]              RDATA,
    output logic [1:0]               RRESP,
    output logic                     RVALID,
    input  logic                     RREADY,
    output logic [NUM_REGS*32-1:0]   REG_Q,
    output logic [NUM_REGS-1:0]      REG_WE
);

    logic [NUM_REGS-1:0][AXI_DATA_W-1:0] regs_q;
    logic [NUM_REGS-1:0]                 reg_we_q, reg_we_d;

    logic                  wr_en;
    logic [IDX_W-1:0]      wr_idx;
    logic [AXI_DATA_W-1:0] wr_data;
    logic [AXI_STRB_W-1:0] wr_strb;

    rd_state_e             r_state_q, r_state_d;
    logic                  arready_q, arready_d;
    logic [AXI_DATA_W-1:0] rdata_q, rdata_d, rd_word;
    logic [1:0]            rresp_q, rresp_d;
    logic                  ar_hs, ar_in_range;
    logic [IDX_W-1:0]      ar_idx;

    logic unused_ok;
    assign unused_ok = ^{AWADDR[1:0], ARADDR[1:0], AWCACHE, AWPROT, ARCACHE, ARPROT};

    axi4_lite_slave_write_fsm #(.NUM_REGS(NUM_REGS)) u_write_fsm (
        .clk_i     (ACLK),
        .rst_ni    (ARESETn),
        .awaddr_i  (AWADDR[31:2]),
        .awvalid_i (AWVALID),
        .awready_o (AWREADY),
        .wdata_i   (WDATA),
        .wstrb_i   (WSTRB),
        .wvalid_i  (WVALID),
        .wready_o  (WREADY),
        .bvalid_o  (BVALID),
        .bready_i  (BREADY),
        .bresp_o   (BRESP),
        .wr_en_o   (wr_en),
        .wr_idx_o  (wr_idx),
        .wr_data_o (wr_data),
        .wr_strb_o (wr_strb)
    );

    always_comb begin
        reg_we_d = '0;
        for (int i = 0; i < NUM_REGS; i++)
            reg_we_d[i] = wr_en && (wr_idx == IDX_W'(i));
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            regs_q   <= '0;
            reg_we_q <= '0;
        end else begin
            reg_we_q <= reg_we_d;
            for (int i = 0; i < NUM_REGS; i++)
                for (int b = 0; b < AXI_STRB_W; b++)
                    if (reg_we_d[i] && wr_strb[b])
                        regs_q[i][8*b +: 8] <= wr_data[8*b +: 8];
        end
    end

    assign REG_Q  = regs_q;
    assign REG_WE = reg_we_q;

    assign ar_hs       = ARVALID & arready_q;
    assign ar_idx      = ARADDR[IDX_W+1:2];
    assign ar_in_range = word_in_range(ARADDR[31:2], NUM_REGS);

    // Reads sample regs_q before any same-edge write lands, so they see the old value
    always_comb begin
        rd_word = '0;
        for (int i = 0; i < NUM_REGS; i++)
            if (ar_idx == IDX_W'(i)) rd_word = regs_q[i];
    end

    always_comb begin
        r_state_d = r_state_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        case (r_state_q)
            R_IDLE: begin
                if (ar_hs) begin
                    rdata_d   = ar_in_range ? rd_word : '0;
                    rresp_d   = ar_in_range ? RESP_OKAY : RESP_OOR;
                    r_state_d = R_DATA;
                end
            end
            R_DATA: begin
                if (RREADY) r_state_d = R_IDLE;
            end
        endcase
        arready_d = (r_state_d == R_IDLE);
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_state_q <= R_IDLE;
            arready_q <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= RESP_OKAY;
        end else begin
            r_state_q <= r_state_d;
            arready_q <= arready_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
        end
    end

    assign ARREADY = arready_q;
    assign RVALID  = (r_state_q == R_DATA);
    assign RDATA   = rdata_q;
    assign RRESP   = rresp_q;

endmodule

// File: tb/tb_axi4_lite_slave_regs.sv
// Directed bench for axi4_lite_slave_regs: inputs change and outputs are sampled on the falling edge.
module tb_axi4_lite_slave_regs;

    localparam int N = 16;
`ifdef AXI4_LITE_SLAVE_REGS_SLVERR_EN
    localparam logic [1:0] OOR = 2'b10;
`else
    localparam logic [1:0] OOR = 2'b00;
`endif

    logic          ACLK = 1'b0;
    logic          ARESETn;
    logic [31:0]   AWADDR, WDATA, ARADDR, RDATA;
    logic [3:0]    AWCACHE, ARCACHE, WSTRB;
    logic [2:0]    AWPROT, ARPROT;
    logic          AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
    logic          ARVALID, ARREADY, RVALID, RREADY;
    logic [1:0]    BRESP, RRESP;
    logic [N*32-1:0] REG_Q;
    logic [N-1:0]  REG_WE;

    logic [N*32-1:0] exp_q;
    int n_vec = 0;
    int n_err = 0;

    always #5 ACLK = ~ACLK;

    axi4_lite_slave_regs #(.NUM_REGS(N)) dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .AWADDR(AWADDR), .AWCACHE(AWCACHE), .AWPROT(AWPROT), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
        .BVALID(BVALID), .BREADY(BREADY), .BRESP(BRESP),
        .ARADDR(ARADDR), .ARCACHE(ARCACHE), .ARPROT(ARPROT), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
        .REG_Q(REG_Q), .REG_WE(REG_WE)
    );

    task automatic tick();
        @(negedge ACLK);
    endtask

    task automatic drive_aw(input logic [31:0] a);
        AWADDR = a; AWVALID = 1'b1;
    endtask

    task automatic drive_w(input logic [31:0] d, input logic [3:0] s);
        WDATA = d; WSTRB = s; WVALID = 1'b1;
    endtask

    task automatic drop_valids();
        AWVALID = 1'b0; WVALID = 1'b0; ARVALID = 1'b0;
    endtask

    task automatic release_b();
        BREADY = 1'b1; tick(); BREADY = 1'b0;
    endtask

    task automatic release_r();
        RREADY = 1'b1; tick(); RREADY = 1'b0;
    endtask

    task automatic test_reset();
        ARESETn = 1'b0;
        repeat (3) tick();
        n_vec++; if ({AWREADY, WREADY, ARREADY} !== 3'b000) begin n_err++; $display("FAIL reset_readies got %b exp 000", {AWREADY, WREADY, ARREADY}); end
        n_vec++; if ({BVALID, RVALID, BRESP, RRESP} !== 6'b0) begin n_err++; $display("FAIL reset_resp got %b exp 000000", {BVALID, RVALID, BRESP, RRESP}); end
        n_vec++; if (REG_Q !== '0 || REG_WE !== '0 || RDATA !== '0) begin n_err++; $display("FAIL reset_data reg_we=%h rdata=%h exp 0", REG_WE, RDATA); end
        ARESETn = 1'b1;
        tick();
        n_vec++; if ({AWREADY, WREADY, ARREADY} !== 3'b111) begin n_err++; $display("FAIL release_readies got %b exp 111", {AWREADY, WREADY, ARREADY}); end
    endtask

    task automatic test_aw_w_same();
        drive_aw(32'h04); drive_w(32'hDEADBEEF, 4'hF);
        tick(); drop_valids();
        exp_q[32*1 +: 32] = 32'hDEADBEEF;
        n_vec++; if ({BVALID, BRESP} !== 3'b100) begin n_err++; $display("FAIL same_b got %b exp 100", {BVALID, BRESP}); end
        n_vec++; if (REG_Q !== exp_q) begin n_err++; $display("FAIL same_word1 got %h exp deadbeef", REG_Q[32 +: 32]); end
        n_vec++; if (REG_WE !== 16'h0002) begin n_err++; $display("FAIL same_we got %h exp 0002", REG_WE); end
        n_vec++; if ({AWREADY, WREADY} !== 2'b00) begin n_err++; $display("FAIL same_resp_readies got %b exp 00", {AWREADY, WREADY}); end
        release_b();
        n_vec++; if ({BVALID, AWREADY, WREADY, REG_WE} !== {3'b011, 16'h0}) begin n_err++; $display("FAIL same_after_b got bv=%b rdy=%b%b we=%h exp 0 11 0000", BVALID, AWREADY, WREADY, REG_WE); end
    endtask

    task automatic test_w_first();
        drive_w(32'h11223344, 4'h3);
        tick(); drop_valids();
        n_vec++; if ({AWREADY, WREADY, BVALID} !== 3'b100) begin n_err++; $display("FAIL wfirst_have_d got %b exp 100", {AWREADY, WREADY, BVALID}); end
        tick(); tick();
        drive_aw(32'h08);
        tick(); drop_valids();
        exp_q[32*2 +: 32] = 32'h00003344;
        n_vec++; if (REG_Q !== exp_q) begin n_err++; $display("FAIL wfirst_word2 got %h exp 00003344", REG_Q[64 +: 32]); end
        n_vec++; if (REG_WE !== 16'h0004) begin n_err++; $display("FAIL wfirst_we got %h exp 0004", REG_WE); end
        for (int i = 0; i < 4; i++) begin
            n_vec++; if ({BVALID, BRESP, AWREADY, WREADY} !== 5'b10000) begin n_err++; $display("FAIL wfirst_hold%0d got %b exp 10000", i, {BVALID, BRESP, AWREADY, WREADY}); end
            tick();
        end
        release_b();
        n_vec++; if (BVALID !== 1'b0) begin n_err++; $display("FAIL wfirst_b_done got %b exp 0", BVALID); end
    endtask

    task automatic test_read();
        ARADDR = 32'h04; ARVALID = 1'b1;
        tick(); drop_valids();
        for (int i = 0; i < 3; i++) begin
            n_vec++; if ({RVALID, ARREADY, RRESP, RDATA} !== {4'b1000, 32'hDEADBEEF}) begin n_err++; $display("FAIL read_hold%0d got v=%b ar=%b r=%b d=%h exp 1 0 00 deadbeef", i, RVALID, ARREADY, RRESP, RDATA); end
            if (i < 2) tick();
        end
        release_r();
        n_vec++; if ({RVALID, ARREADY} !== 2'b01) begin n_err++; $display("FAIL read_done got %b exp 01", {RVALID, ARREADY}); end
    endtask

    task automatic test_strb_zero();
        drive_aw(32'h04); drive_w(32'hFFFFFFFF, 4'h0);
        tick(); drop_valids();
        n_vec++; if ({BVALID, BRESP, REG_WE} !== {3'b100, 16'h0}) begin n_err++; $display("FAIL strb0_b got bv=%b br=%b we=%h exp 1 00 0000", BVALID, BRESP, REG_WE); end
        n_vec++; if (REG_Q !== exp_q) begin n_err++; $display("FAIL strb0_word1 got %h exp deadbeef", REG_Q[32 +: 32]); end
        release_b();
    endtask

    task automatic test_last_reg();
        drive_aw(32'h3E); drive_w(32'hCAFEBABE, 4'hC);
        tick(); drop_valids();
        exp_q[32*15 +: 32] = 32'hCAFE0000;
        n_vec++; if (REG_Q !== exp_q) begin n_err++; $display("FAIL last_word15 got %h exp cafe0000", REG_Q[480 +: 32]); end
        n_vec++; if (REG_WE !== 16'h8000) begin n_err++; $display("FAIL last_we got %h exp 8000", REG_WE); end
        release_b();
    endtask

    task automatic test_out_of_range();
        drive_aw(32'h40); drive_w(32'hFFFFFFFF, 4'hF);
        tick(); drop_valids();
        n_vec++; if ({BVALID, BRESP} !== {1'b1, OOR}) begin n_err++; $display("FAIL oor_b got %b exp %b", {BVALID, BRESP}, {1'b1, OOR}); end
        n_vec++; if (REG_Q !== exp_q || REG_WE !== '0) begin n_err++; $display("FAIL oor_regs changed we=%h exp 0000", REG_WE); end
        release_b();
        ARADDR = 32'h40; ARVALID = 1'b1;
        tick(); drop_valids();
        n_vec++; if ({RVALID, RRESP, RDATA} !== {1'b1, OOR, 32'h0}) begin n_err++; $display("FAIL oor_r got v=%b r=%b d=%h exp 1 %b 0", RVALID, RRESP, RDATA, OOR); end
        release_r();
    endtask

    task automatic test_same_edge();
        drive_aw(32'h00); drive_w(32'hA5A5A5A5, 4'hF);
        ARADDR = 32'h00; ARVALID = 1'b1;
        tick(); drop_valids();
        exp_q[0 +: 32] = 32'hA5A5A5A5;
        n_vec++; if ({RVALID, BVALID, RDATA} !== {2'b11, 32'h0}) begin n_err++; $display("FAIL edge_old got rv=%b bv=%b d=%h exp 1 1 0", RVALID, BVALID, RDATA); end
        n_vec++; if (REG_Q !== exp_q) begin n_err++; $display("FAIL edge_word0 got %h exp a5a5a5a5", REG_Q[0 +: 32]); end
        BREADY = 1'b1; RREADY = 1'b1; tick(); BREADY = 1'b0; RREADY = 1'b0;
        ARADDR = 32'h00; ARVALID = 1'b1;
        tick(); drop_valids();
        n_vec++; if (RDATA !== 32'hA5A5A5A5) begin n_err++; $display("FAIL edge_new got %h exp a5a5a5a5", RDATA); end
        release_r();
    endtask

    task automatic test_reset_mid();
        drive_aw(32'h0C);
        tick(); drop_valids();
        n_vec++; if ({AWREADY, WREADY} !== 2'b01) begin n_err++; $display("FAIL mid_have_a got %b exp 01", {AWREADY, WREADY}); end
        #2 ARESETn = 1'b0;
        #1;
        exp_q = '0;
        n_vec++; if ({AWREADY, WREADY, ARREADY, BVALID, RVALID, BRESP, RRESP} !== 9'b0) begin n_err++; $display("FAIL mid_rst_ctrl got %b exp 0", {AWREADY, WREADY, ARREADY, BVALID, RVALID, BRESP, RRESP}); end
        n_vec++; if (REG_Q !== exp_q || REG_WE !== '0 || RDATA !== '0) begin n_err++; $display("FAIL mid_rst_data rdata=%h we=%h exp 0", RDATA, REG_WE); end
        tick(); ARESETn = 1'b1; tick();
        n_vec++; if ({AWREADY, WREADY, ARREADY} !== 3'b111) begin n_err++; $display("FAIL mid_release got %b exp 111", {AWREADY, WREADY, ARREADY}); end
        drive_w(32'h12345678, 4'hF);
        tick(); drop_valids();
        n_vec++; if ({BVALID, AWREADY, WREADY} !== 3'b010 || REG_Q !== exp_q) begin n_err++; $display("FAIL mid_stale got bv=%b rdy=%b%b exp 0 10, no write", BVALID, AWREADY, WREADY); end
        drive_aw(32'h10);
        tick(); drop_valids();
        exp_q[32*4 +: 32] = 32'h12345678;
        n_vec++; if (REG_Q !== exp_q || REG_WE !== 16'h0010) begin n_err++; $display("FAIL mid_fresh word3=%h word4=%h we=%h exp 0 12345678 0010", REG_Q[96 +: 32], REG_Q[128 +: 32], REG_WE); end
        release_b();
    endtask

    initial begin
        ARESETn = 1'b0;
        AWADDR = '0; AWCACHE = '0; AWPROT = '0; AWVALID = 1'b0;
        WDATA = '0; WSTRB = '0; WVALID = 1'b0; BREADY = 1'b0;
        ARADDR = '0; ARCACHE = '0; ARPROT = '0; ARVALID = 1'b0; RREADY = 1'b0;
        exp_q = '0;
        test_reset();
        test_aw_w_same();
        test_w_first();
        test_read();
        test_strb_zero();
        test_last_reg();
        test_out_of_range();
        test_same_edge();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
